// File: rtl/snoop_pkg.sv
// Shared constants for the snooping-bus memory controller: message types, field
// positions within a bus message, CPU ids and the memory reset image.
package snoop_pkg;

    localparam logic [1:0] MSG_DATA  = 2'b00;
    localparam logic [1:0] MSG_WB    = 2'b01;
    localparam logic [1:0] MSG_WMISS = 2'b10;
    localparam logic [1:0] MSG_RMISS = 2'b11;

    localparam int ID_HI   = 9;
    localparam int ID_LO   = 8;
    localparam int TYPE_HI = 7;
    localparam int TYPE_LO = 6;
    localparam int TAG_HI  = 5;
    localparam int TAG_LO  = 3;
    localparam int DATA_HI = 2;
    localparam int DATA_LO = 0;

    localparam logic [1:0] CPU0 = 2'd0;
    localparam logic [1:0] CPU1 = 2'd1;
    localparam logic [1:0] CPU2 = 2'd2;
    localparam logic [1:0] CPU3 = 2'd3;

    localparam int TAG_W   = 3;
    localparam int DATA_W  = 3;
    localparam int ENTRY_W = TAG_W + DATA_W;

    // Power-on contents {tag, data}; the last entry is the invalid location.
    function automatic logic [ENTRY_W-1:0] reset_image(input int idx);
        case (idx)
            1:       return 6'b001_010;
            2:       return 6'b010_001;
            3:       return 6'b011_101;
            4:       return 6'b100_000;
            5:       return 6'b101_111;
            6:       return 6'b110_011;
            default: return 6'b000_000;
        endcase
    endfunction

endpackage

// File: rtl/snoop_mem_array.sv
// Main-memory storage: DEPTH entries of {tag, data}, reloaded on clear, with a
// synchronous data-only write port and a combinational read port.
module snoop_mem_array
    import snoop_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic [ENTRY_W-1:0] rd_entry
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // The invalid entry is never written so it always holds its reset image.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= reset_image(i);
            end
        end else if (wr_en && (wr_tag != TAG_W'(DEPTH - 1))) begin
            mem[wr_tag][DATA_W-1:0] <= wr_data;
        end
    end

    assign rd_entry = mem[rd_tag];

endmodule

// File: rtl/snoop_mem_ctrl.sv
// Snooping-bus memory controller: captures a miss, holds a snoop window for
// write-backs, reads the array after the access latency and issues a DATA reply.
module snoop_mem_ctrl
    import snoop_pkg::*;
#(
    parameter int SNOOP_WIN = 3,
    parameter int MEM_LAT   = 2,
    parameter int DEPTH     = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       bus_valid,
    input  logic [9:0] bus,
    output logic       reply_vld,
    output logic [9:0] reply,
    output logic       reply_err,
    output logic       busy,
    output logic       req_drop
);

    localparam int CNT_MAX = (SNOOP_WIN > MEM_LAT) ? SNOOP_WIN : MEM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SNOOP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_REPLY  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_term;
    logic [1:0]         req_id;
    logic [TAG_W-1:0]   req_tag;
    logic               abort;
    logic [ENTRY_W-1:0] rd_entry;

    logic [1:0]        msg_id;
    logic [1:0]        msg_type;
    logic [TAG_W-1:0]  msg_tag;
    logic [DATA_W-1:0] msg_data;
    logic              is_wb;
    logic              is_miss;
    logic              in_window;

    assign msg_id    = bus[ID_HI:ID_LO];
    assign msg_type  = bus[TYPE_HI:TYPE_LO];
    assign msg_tag   = bus[TAG_HI:TAG_LO];
    assign msg_data  = bus[DATA_HI:DATA_LO];
    assign is_wb     = bus_valid && (msg_type == MSG_WB);
    assign is_miss   = bus_valid && ((msg_type == MSG_RMISS) || (msg_type == MSG_WMISS));
    assign in_window = (state == S_SNOOP) || (state == S_ACCESS);
    assign busy      = (state != S_IDLE);

    snoop_mem_array #(.DEPTH(DEPTH)) u_array (
        .clock    (clock),
        .clear    (clear),
        .wr_en    (is_wb),
        .wr_tag   (msg_tag),
        .wr_data  (msg_data),
        .rd_tag   (req_tag),
        .rd_entry (rd_entry)
    );

    always_comb begin
        cnt_term = (state == S_SNOOP) ? CNT_W'(SNOOP_WIN - 1) : CNT_W'(MEM_LAT - 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (is_miss) state_nxt = S_SNOOP;
            S_SNOOP:  if (cnt == cnt_term) state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == cnt_term) state_nxt = S_REPLY;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The reply is registered on the last ACCESS cycle so it is visible during REPLY.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_id    <= '0;
            req_tag   <= '0;
            abort     <= 1'b0;
            reply_vld <= 1'b0;
            reply_err <= 1'b0;
            reply     <= '0;
            req_drop  <= 1'b0;
        end else begin
            state     <= state_nxt;
            reply_vld <= 1'b0;
            reply_err <= 1'b0;
            req_drop  <= busy && is_miss;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != cnt_term) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == S_IDLE) && is_miss) begin
                req_id  <= msg_id;
                req_tag <= msg_tag;
                abort   <= 1'b0;
            end else if (in_window) begin
                abort <= abort | (is_wb && (msg_tag == req_tag));
            end

            if ((state == S_ACCESS) && (cnt == cnt_term)) begin
                reply_vld <= 1'b1;
                if (req_tag == TAG_W'(DEPTH - 1)) begin
                    reply_err <= 1'b1;
                    reply     <= {req_id, MSG_DATA, req_tag, 3'b000};
                end else begin
                    reply     <= {req_id, MSG_DATA, rd_entry};
                end
            end
        end
    end

endmodule

// File: tb/tb_snoop_mem_ctrl.sv
// Scoreboard bench for snoop_mem_ctrl: directed bus messages push expected replies,
// a negedge monitor pops and compares every reply the controller issues.
module tb_snoop_mem_ctrl;
    import snoop_pkg::*;

    typedef struct {
        logic [9:0] reply;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clock;
    logic       clear;
    logic       bus_valid;
    logic [9:0] bus;
    logic       reply_vld;
    logic [9:0] reply;
    logic       reply_err;
    logic       busy;
    logic       req_drop;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   drop_cnt;

    snoop_mem_ctrl dut (
        .clock     (clock),
        .clear     (clear),
        .bus_valid (bus_valid),
        .bus       (bus),
        .reply_vld (reply_vld),
        .reply     (reply),
        .reply_err (reply_err),
        .busy      (busy),
        .req_drop  (req_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every reply strobe must match the oldest pending expectation.
    always @(negedge clock) begin
        if (!clear) begin
            if (req_drop) drop_cnt++;
            if (reply_vld) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_reply: got %03h, expected none", reply);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("reply_word", 32'(reply), 32'(e.reply));
                    check("reply_err", 32'(reply_err), 32'(e.err));
                    check("reply_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Drives one message for one cycle; cap is the cycle count after the sampling edge.
    task automatic apply_stimulus(input logic [1:0] id, input logic [1:0] typ,
                                  input logic [2:0] tag, input logic [2:0] data,
                                  output int cap);
        @(negedge clock);
        bus_valid = 1'b1;
        bus       = {id, typ, tag, data};
        cap       = cyc + 1;
        @(negedge clock);
        bus_valid = 1'b0;
        bus       = '0;
    endtask

    task automatic expect_reply(input logic [9:0] r, input logic err, input int cap);
        exp_t e;
        e.reply = r;
        e.err   = err;
        e.cyc   = cap + 5;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
        sb.delete();
    endtask

    initial begin
        int cap;
        int busy_cycles;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        drop_cnt  = 0;
        clear     = 1'b1;
        bus_valid = 1'b0;
        bus       = '0;

        repeat (2) @(negedge clock);
        check("rst_reply_vld", 32'(reply_vld), 32'd0);
        check("rst_reply", 32'(reply), 32'd0);
        check("rst_reply_err", 32'(reply_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_drop", 32'(req_drop), 32'd0);
        clear = 1'b0;
        @(negedge clock);

        // 1: plain read miss, latency and busy span.
        apply_stimulus(CPU1, MSG_RMISS, 3'b000, 3'b000, cap);
        expect_reply(10'b01_00_000_000, 1'b0, cap);
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cycles++;
            @(negedge clock);
        end
        check("t1_busy_cycles", 32'(busy_cycles), 32'd6);
        wait_drain("t1_drain");

        // 2: write-back for the same tag during the snoop window.
        apply_stimulus(CPU0, MSG_RMISS, 3'b001, 3'b000, cap);
        expect_reply(10'b00_00_001_011, 1'b0, cap);
        apply_stimulus(CPU2, MSG_WB, 3'b001, 3'b011, cap);
        wait_drain("t2a_drain");
        apply_stimulus(CPU2, MSG_RMISS, 3'b001, 3'b000, cap);
        expect_reply(10'b10_00_001_011, 1'b0, cap);
        wait_drain("t2b_drain");

        // 3: idle write-back then write miss.
        apply_stimulus(CPU1, MSG_WB, 3'b101, 3'b100, cap);
        apply_stimulus(CPU3, MSG_WMISS, 3'b101, 3'b000, cap);
        expect_reply(10'b11_00_101_100, 1'b0, cap);
        wait_drain("t3_drain");
        check("t3_no_drop", 32'(drop_cnt), 32'd0);

        // 4: second miss during ACCESS is dropped.
        apply_stimulus(CPU1, MSG_RMISS, 3'b010, 3'b000, cap);
        expect_reply(10'b01_00_010_001, 1'b0, cap);
        repeat (2) @(negedge clock);
        apply_stimulus(CPU2, MSG_RMISS, 3'b011, 3'b000, cap);
        wait_drain("t4_drain");
        repeat (8) @(negedge clock);
        check("t4_drop_once", 32'(drop_cnt), 32'd1);

        // 5: invalid entry, including after a write-back to it.
        apply_stimulus(CPU2, MSG_RMISS, 3'b111, 3'b000, cap);
        expect_reply(10'b10_00_111_000, 1'b1, cap);
        wait_drain("t5a_drain");
        apply_stimulus(CPU0, MSG_WB, 3'b111, 3'b101, cap);
        apply_stimulus(CPU0, MSG_RMISS, 3'b111, 3'b000, cap);
        expect_reply(10'b00_00_111_000, 1'b1, cap);
        wait_drain("t5b_drain");

        // 6: clear in the middle of a snoop window.
        apply_stimulus(CPU3, MSG_RMISS, 3'b001, 3'b000, cap);
        @(posedge clock);
        #2 clear = 1'b1;
        #1;
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_vld_async", 32'(reply_vld), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        repeat (10) @(negedge clock);
        apply_stimulus(CPU3, MSG_RMISS, 3'b001, 3'b000, cap);
        expect_reply(10'b11_00_001_010, 1'b0, cap);
        wait_drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
